// File: rtl/ex_alu_datapath.sv
// ex_alu_datapath: execute-stage forwarding muxes, ALU control decode, ALU and EX/MEM result register.
// Optional: define ALU_OVERFLOW_EN to add the registered signed-overflow flag ovf_q.
module ex_alu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       aluop,
    input  logic             andi,
    input  logic             ori,
    input  logic             addi,
    input  logic [5:0]       funct,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [WIDTH-1:0] mem_data,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf_q
`endif
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_NOP = 4'b1111;
    logic [WIDTH-1:0] a, b;
    logic [3:0] funct_ctl, imm_ctl;
    logic slt;
    assign a = fwd_a == 2'b00 ? ex_a : fwd_a == 2'b01 ? wb_data : fwd_a == 2'b10 ? mem_data : '0;
    assign b = fwd_b == 2'b00 ? ex_b : fwd_b == 2'b01 ? wb_data : fwd_b == 2'b10 ? mem_data : '0;
    assign slt = $signed(a) < $signed(b);
    // Decode funct for R-type and the immediate flags (andi > ori > addi) for I-type.
    always_comb begin
        funct_ctl = funct == 6'b100000 ? OP_ADD :
                    funct == 6'b100010 ? OP_SUB :
                    funct == 6'b100100 ? OP_AND :
                    funct == 6'b100101 ? OP_OR  :
                    funct == 6'b100111 ? OP_NOR :
                    funct == 6'b101010 ? OP_SLT : OP_NOP;
        imm_ctl = andi ? OP_AND : ori ? OP_OR : OP_ADD;
        alu_ctl = aluop == 2'b00 ? OP_ADD : aluop == 2'b01 ? OP_SUB : aluop == 2'b10 ? funct_ctl : imm_ctl;
    end
    // ALU proper; unlisted codes (including NOP) yield 0.
    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR:  alu_result = ~(a | b);
            default: alu_result = '0;
        endcase
    end
    // EX/MEM result register with zero flag, updated every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= alu_result;
            zero_q   <= alu_result == '0;
        end
    end
`ifdef ALU_OVERFLOW_EN
    logic ovf;
    assign ovf = (alu_ctl == OP_ADD && a[WIDTH-1] == b[WIDTH-1] && alu_result[WIDTH-1] != a[WIDTH-1]) ||
                 (alu_ctl == OP_SUB && a[WIDTH-1] != b[WIDTH-1] && alu_result[WIDTH-1] != a[WIDTH-1]);
    // Register signed overflow of ADD/SUB alongside the result.
    always_ff @(posedge clock) begin
        if (reset) ovf_q <= 1'b0;
        else ovf_q <= ovf;
    end
`endif
endmodule

// File: tb/tb_ex_alu_datapath.sv
// tb_ex_alu_datapath: directed self-checking bench for ex_alu_datapath (covers ALU_OVERFLOW_EN when defined).
module tb_ex_alu_datapath;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  aluop;
    logic        andi, ori, addi;
    logic [5:0]  funct;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] ex_a, ex_b, wb_data, mem_data;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result, result_q;
    logic        zero_q;
`ifdef ALU_OVERFLOW_EN
    logic        ovf_q;
`endif
    int n_checks = 0;
    int n_fail = 0;

    ex_alu_datapath #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .aluop(aluop), .andi(andi), .ori(ori), .addi(addi),
        .funct(funct), .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_a(ex_a), .ex_b(ex_b),
        .wb_data(wb_data), .mem_data(mem_data), .alu_ctl(alu_ctl), .alu_result(alu_result),
        .result_q(result_q), .zero_q(zero_q)
`ifdef ALU_OVERFLOW_EN
        , .ovf_q(ovf_q)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; aluop = 2'b00; andi = 0; ori = 0; addi = 0; funct = 6'b0;
        fwd_a = 2'b00; fwd_b = 2'b00; ex_a = 32'd9; ex_b = 32'd9; wb_data = 0; mem_data = 0;
        tick();
        check("reset_result_q", result_q, 32'd0);
        check("reset_zero_q", {31'd0, zero_q}, 32'd1);
`ifdef ALU_OVERFLOW_EN
        check("reset_ovf_q", {31'd0, ovf_q}, 32'd0);
`endif
        reset = 1'b0;
        aluop = 2'b10; funct = 6'b100000; ex_a = 32'd5; ex_b = 32'd7; #1;
        check("rtype_add_ctl", {28'd0, alu_ctl}, 32'h2);
        check("rtype_add_res", alu_result, 32'd12);
        tick();
        check("rtype_add_q", result_q, 32'd12);
        check("rtype_add_zero", {31'd0, zero_q}, 32'd0);
        aluop = 2'b01; ex_a = 32'h1234; ex_b = 32'h1234; #1;
        check("branch_sub_ctl", {28'd0, alu_ctl}, 32'h6);
        check("branch_sub_res", alu_result, 32'd0);
        tick();
        check("branch_sub_q", result_q, 32'd0);
        check("branch_sub_zero", {31'd0, zero_q}, 32'd1);
        aluop = 2'b00; ex_a = 32'd1; wb_data = 32'd2; mem_data = 32'd3; ex_b = 32'd10;
        fwd_a = 2'b00; #1; check("fwd_a_00", alu_result, 32'd11);
        fwd_a = 2'b01; #1; check("fwd_a_01", alu_result, 32'd12);
        fwd_a = 2'b10; #1; check("fwd_a_10", alu_result, 32'd13);
        fwd_a = 2'b11; #1; check("fwd_a_11", alu_result, 32'd10);
        fwd_a = 2'b00; fwd_b = 2'b01; #1; check("fwd_b_01", alu_result, 32'd3);
        fwd_b = 2'b10; #1; check("fwd_b_10", alu_result, 32'd4);
        fwd_b = 2'b11; #1; check("fwd_b_11", alu_result, 32'd1);
        fwd_b = 2'b00;
        aluop = 2'b11; andi = 1; ori = 1; ex_a = 32'hF0F0; ex_b = 32'h0FF0; #1;
        check("imm_prio_ctl", {28'd0, alu_ctl}, 32'h0);
        check("imm_prio_res", alu_result, 32'h00F0);
        andi = 0; #1;
        check("imm_ori_res", alu_result, 32'hFFF0);
        ori = 0; #1;
        check("imm_none_res", alu_result, 32'h100E0);
        addi = 1; #1;
        check("imm_addi_ctl", {28'd0, alu_ctl}, 32'h2);
        addi = 0;
        aluop = 2'b10; andi = 1; funct = 6'b100101; #1;
        check("flags_ignored_ctl", {28'd0, alu_ctl}, 32'h1);
        andi = 0;
        funct = 6'b101010; ex_a = 32'hFFFFFFFF; ex_b = 32'd1; #1;
        check("slt_neg_res", alu_result, 32'd1);
        ex_a = 32'h80000000; ex_b = 32'd0; #1;
        check("slt_min_res", alu_result, 32'd1);
        ex_a = 32'd1; ex_b = 32'hFFFFFFFF; #1;
        check("slt_false_res", alu_result, 32'd0);
        funct = 6'b100111; ex_a = 32'd0; ex_b = 32'd0; #1;
        check("nor_res", alu_result, 32'hFFFFFFFF);
        funct = 6'b100100; ex_a = 32'hFF00FF00; ex_b = 32'h0FF00FF0; #1;
        check("and_res", alu_result, 32'h0F000F00);
        funct = 6'b100010; ex_a = 32'd0; ex_b = 32'd1; #1;
        check("sub_wrap_res", alu_result, 32'hFFFFFFFF);
        funct = 6'b111111; ex_a = 32'd3; ex_b = 32'd4; #1;
        check("nop_ctl", {28'd0, alu_ctl}, 32'hF);
        check("nop_res", alu_result, 32'd0);
        funct = 6'b100000; ex_a = 32'h7FFFFFFF; ex_b = 32'd1; #1;
        check("add_ovf_res", alu_result, 32'h80000000);
        tick();
        check("add_ovf_q", result_q, 32'h80000000);
`ifdef ALU_OVERFLOW_EN
        check("add_ovf_flag", {31'd0, ovf_q}, 32'd1);
        funct = 6'b100010; ex_a = 32'h80000000; ex_b = 32'd1; tick();
        check("sub_ovf_flag", {31'd0, ovf_q}, 32'd1);
        ex_a = 32'd5; ex_b = 32'd3; tick();
        check("sub_no_ovf_flag", {31'd0, ovf_q}, 32'd0);
        funct = 6'b100000; ex_a = 32'h7FFFFFFF; ex_b = 32'd1; tick();
`endif
        aluop = 2'b00; ex_a = 32'h50; ex_b = 32'h05; reset = 1'b1; tick();
        check("reset_mid_q", result_q, 32'd0);
        check("reset_mid_zero", {31'd0, zero_q}, 32'd1);
`ifdef ALU_OVERFLOW_EN
        check("reset_mid_ovf", {31'd0, ovf_q}, 32'd0);
`endif
        reset = 1'b0; tick();
        check("post_reset_q", result_q, 32'h55);
        check("post_reset_zero", {31'd0, zero_q}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_alu_datapath.md
Name: ex_alu_datapath

Overview:
Execute-stage datapath of the 5-stage pipelined CPU. It combines three pieces:
- two 4:1 forwarding muxes (BIGMUX2 function) that pick the ALU operands;
- the ALU control decoder (ALUControl function) that turns aluop/funct/immediate-type flags into a 4-bit ALU operation;
- the 32-bit ALU.

The result is available combinationally for bypass, and a registered copy plus zero flag feed the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width in bits; all data ports use it.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- aluop  input  2  ALU operation class from the ID/EX control field.
- andi  input  1  immediate-AND instruction flag.
- ori  input  1  immediate-OR instruction flag.
- addi  input  1  immediate-ADD instruction flag.
- funct  input  6  function field, bits [5:0] of the sign-extended immediate.
- fwd_a  input  2  operand A forwarding select.
- fwd_b  input  2  operand B forwarding select.
- ex_a  input  WIDTH  register A value from ID/EX.
- ex_b  input  WIDTH  operand B after the immediate/register select.
- wb_data  input  WIDTH  write-back stage result.
- mem_data  input  WIDTH  MEM-stage ALU result.
- alu_ctl  output  4  decoded ALU operation.
- alu_result  output  WIDTH  combinational ALU result.
- result_q  output  WIDTH  registered ALU result.
- zero_q  output  1  registered flag, high when the registered result is 0.

Behaviour:

Forwarding muxes (combinational, identical for A and B):
- sel 00: ex_a / ex_b.
- sel 01: wb_data.
- sel 10: mem_data.
- sel 11: constant 0.

ALU control (combinational):
- aluop 00 -> ADD (0010), for load/store address.
- aluop 01 -> SUB (0110), for branch compare.
- aluop 10 -> decode funct:
  - 100000 ADD 0010.
  - 100010 SUB 0110.
  - 100100 AND 0000.
  - 100101 OR 0001.
  - 100111 NOR 1100.
  - 101010 SLT 0111.
  - any other funct -> 1111 (NOP).
- aluop 11 -> immediate class, priority andi > ori > addi:
  - andi -> AND.
  - ori -> OR.
  - addi -> ADD.
  - no flag set -> ADD.
- andi/ori/addi are ignored unless aluop = 11.

ALU (combinational, alu_result = f(A, B)):
- AND: A & B.
- OR: A | B.
- ADD: A + B, modulo 2^WIDTH, carry discarded.
- SUB: A - B, modulo 2^WIDTH.
- SLT: 1 if signed A < signed B, else 0, zero-extended to WIDTH.
- NOR: ~(A | B).
- 1111 and any unlisted code: result 0.

Register stage:
- On each rising clock edge: result_q <= alu_result and zero_q <= (alu_result == 0).
- Latency: 1 cycle from operand/control change to result_q.
- reset high at a clock edge: result_q <= 0, zero_q <= 1. Reset wins over a simultaneous update; reset mid-operation discards the in-flight result.
- No enable or stall input: the register updates every cycle.

Boundary behaviour:
- ADD 0x7FFFFFFF + 1 = 0x80000000.
- SUB 0 - 1 = 0xFFFFFFFF.
- SLT 0x80000000 vs 0 = 1 (signed compare).

Optional Feature:
Macro ALU_OVERFLOW_EN.
- Defined: adds output ovf_q (1 bit, registered, reset value 0).
  - Set when a signed ADD or SUB overflows: operand signs and result sign are inconsistent.
  - 0 for all other operations.
  - The result value is unaffected.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
1. aluop=10, funct=100000, fwd=00/00, ex_a=5, ex_b=7 -> alu_ctl=0010, alu_result=12, next edge result_q=12, zero_q=0.
2. aluop=01, ex_a=ex_b=0x1234 -> alu_ctl=0110, alu_result=0, zero_q=1 after the edge.
3. Forwarding, with ex_a=1, wb_data=2, mem_data=3, ex_b=10, aluop=00 -> result 11 / 12 / 13 / 10 for fwd_a = 00 / 01 / 10 / 11.
4. aluop=11 with andi=ori=1, ex_a=0xF0F0, ex_b=0x0FF0 -> AND wins, result 0x00F0; with ori only -> 0xFFF0; with no flags -> 0x100E0 (ADD).
5. aluop=10, funct=101010, A=0xFFFFFFFF, B=1 -> result 1; funct=100111, A=B=0 -> 0xFFFFFFFF; funct=111111 -> alu_ctl=1111, result 0.
6. Reset asserted while operands give result 0x55 -> result_q=0, zero_q=1 (ovf_q=0 when ALU_OVERFLOW_EN is defined). With the macro, 0x7FFFFFFF+1 -> ovf_q=1 one edge later.
